// File: rtl/vscale_dmem_responder_pkg.sv
// Shared constants for the vscale data-memory responder:
// size codes, FSM encoding and the byte-lane mask helper.
package vscale_dmem_responder_pkg;

    localparam int XPR_LEN        = 32;
    localparam int MEM_TYPE_WIDTH = 3;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_ILL  = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } dmem_state_e;

    function automatic logic [3:0] byte_mask(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] m;
        m = 4'b0000;
        unique case (1'b1)
            size == SIZE_BYTE: m = 4'b0001 << off;
            size == SIZE_HALF: m = 4'b0011 << off;
            size == SIZE_WORD: m = 4'b1111;
            default:           m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vscale_sram_1rw_be.sv
// Behavioral DEPTH x 32 synchronous SRAM with byte write enables.
// Read-before-write on a same-address collision.
module vscale_sram_1rw_be #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write and registered read
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Slave end of the vscale dmem address/data protocol:
// wait-state FSM, address decode, SRAM and store forwarding.
module vscale_dmem_responder
    import vscale_dmem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dmem_en,
    input  logic                      dmem_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
    input  logic [XPR_LEN-1:0]        dmem_addr,
    input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
    output logic [XPR_LEN-1:0]        dmem_rdata,
    output logic                      dmem_wait,
    output logic                      dmem_badmem_e
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WC   = 4'(WAIT_CYCLES);

    dmem_state_e state;
    dmem_state_e state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;

    logic [AW-1:0] idx_q;
    logic          wen_q;
    logic          bad_q;
    logic [3:0]    be_q;

    logic          kill_q;
    logic          fwd_q;
    logic [3:0]    fwd_be_q;
    logic [31:0]   fwd_wd_q;

    logic          accept;
    logic          in_bad;
    logic          fin_bad;
    logic [3:0]    in_be;
    logic [32:0]   in_off;
    logic [AW-1:0] in_idx;

    logic          re;
    logic          we;
    logic [AW-1:0] ra;
    logic [31:0]   sram_q;
    logic [31:0]   merged;

    logic          unused_size;
    assign unused_size = dmem_size[2];

    // Decode the incoming address phase
    always_comb begin
        in_off = {1'b0, dmem_addr} - {1'b0, BASE_ADDR};
        in_idx = in_off[AW+1:2];
        in_be  = byte_mask(dmem_size[1:0], dmem_addr[1:0]);
        in_bad = in_off[32]
              || (in_off >= SPAN)
              || (dmem_size[1:0] == SIZE_ILL)
              || (dmem_size[1:0] == SIZE_HALF && dmem_addr[0])
              || (dmem_size[1:0] == SIZE_WORD
                  && dmem_addr[1:0] != 2'b00);
    end

    assign accept = dmem_en && (state != ST_WAIT);

    // Next state, wait counter and error flag of the next data phase
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fin_bad  = bad_q;
        unique case (state)
            ST_IDLE, ST_DATA: begin
                state_nx = ST_IDLE;
                cnt_nx   = 4'd0;
                if (accept) begin
                    fin_bad = in_bad;
                    if (WAIT_CYCLES == 0) begin
                        state_nx = ST_DATA;
                    end else begin
                        state_nx = ST_WAIT;
                        cnt_nx   = WC;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nx = ST_DATA;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // FSM state, registered outputs and captured address phase
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= 4'd0;
            dmem_wait     <= 1'b0;
            dmem_badmem_e <= 1'b0;
            idx_q         <= '0;
            wen_q         <= 1'b0;
            bad_q         <= 1'b0;
            be_q          <= 4'b0000;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            dmem_wait     <= (state_nx == ST_WAIT);
            dmem_badmem_e <= (state_nx == ST_DATA) && fin_bad;
            if (accept) begin
                idx_q <= in_idx;
                wen_q <= dmem_wen;
                bad_q <= in_bad;
                be_q  <= in_be;
            end
        end
    end

    assign re = !reset
             && (accept || (state == ST_WAIT && cnt <= 4'd1));
    assign ra = (state == ST_WAIT) ? idx_q : in_idx;
    assign we = !reset && (state == ST_DATA) && wen_q && !bad_q;

    vscale_sram_1rw_be #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .re    (re),
        .raddr (ra),
        .rdata (sram_q),
        .we    (we),
        .be    (be_q),
        .waddr (idx_q),
        .wdata (dmem_wdata_delayed)
    );

    // Track bad-read zeroing and a store landing with the read
    always_ff @(posedge clk) begin
        if (reset) begin
            kill_q   <= 1'b1;
            fwd_q    <= 1'b0;
            fwd_be_q <= 4'b0000;
            fwd_wd_q <= 32'h0;
        end else if (re) begin
            kill_q   <= (state == ST_WAIT) ? bad_q : in_bad;
            fwd_q    <= we && (ra == idx_q);
            fwd_be_q <= be_q;
            fwd_wd_q <= dmem_wdata_delayed;
        end
    end

    // Merge forwarded lanes over the array word
    always_comb begin
        merged = sram_q;
        for (int i = 0; i < 4; i++) begin
            if (fwd_q && fwd_be_q[i]) begin
                merged[8*i +: 8] = fwd_wd_q[8*i +: 8];
            end
        end
        dmem_rdata = kill_q ? 32'h0 : merged;
    end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Directed scoreboard bench for vscale_dmem_responder
// with 0, 3 and 2 wait states.
module tb_vscale_dmem_responder;

    localparam logic [2:0] BYTE  = 3'd0;
    localparam logic [2:0] HALF  = 3'd1;
    localparam logic [2:0] WORD  = 3'd2;
    localparam logic [2:0] ILLSZ = 3'd3;

    typedef struct {
        logic [31:0] rd;
        logic        bad;
        logic        chk_rd;
    } exp_t;

    exp_t sb[$];

    logic        clk;
    logic        rst [3];
    logic        en  [3];
    logic        wen [3];
    logic [2:0]  sz  [3];
    logic [31:0] ad  [3];
    logic [31:0] wd  [3];
    logic [31:0] nwd [3];
    logic [31:0] rd  [3];
    logic        wt  [3];
    logic        be  [3];

    int n_tot  = 0;
    int n_fail = 0;

    vscale_dmem_responder #(
        .BASE_ADDR   (32'h0),
        .DEPTH_WORDS (4096),
        .WAIT_CYCLES (0)
    ) u0 (
        .clk                (clk),
        .reset              (rst[0]),
        .dmem_en            (en[0]),
        .dmem_wen           (wen[0]),
        .dmem_size          (sz[0]),
        .dmem_addr          (ad[0]),
        .dmem_wdata_delayed (wd[0]),
        .dmem_rdata         (rd[0]),
        .dmem_wait          (wt[0]),
        .dmem_badmem_e      (be[0])
    );

    vscale_dmem_responder #(
        .BASE_ADDR   (32'h0),
        .DEPTH_WORDS (4096),
        .WAIT_CYCLES (3)
    ) u1 (
        .clk                (clk),
        .reset              (rst[1]),
        .dmem_en            (en[1]),
        .dmem_wen           (wen[1]),
        .dmem_size          (sz[1]),
        .dmem_addr          (ad[1]),
        .dmem_wdata_delayed (wd[1]),
        .dmem_rdata         (rd[1]),
        .dmem_wait          (wt[1]),
        .dmem_badmem_e      (be[1])
    );

    vscale_dmem_responder #(
        .BASE_ADDR   (32'h0),
        .DEPTH_WORDS (4096),
        .WAIT_CYCLES (2)
    ) u2 (
        .clk                (clk),
        .reset              (rst[2]),
        .dmem_en            (en[2]),
        .dmem_wen           (wen[2]),
        .dmem_size          (sz[2]),
        .dmem_addr          (ad[2]),
        .dmem_wdata_delayed (wd[2]),
        .dmem_rdata         (rd[2]),
        .dmem_wait          (wt[2]),
        .dmem_badmem_e      (be[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end");
        $fatal(1, "watchdog");
    end

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_tot++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic clock(input int d);
        logic acc;
        acc = en[d] && !wt[d];
        @(posedge clk);
        #1;
        if (acc) wd[d] = nwd[d];
    endtask

    task automatic addr_phase(
        input int          d,
        input logic        w,
        input logic [2:0]  s,
        input logic [31:0] a,
        input logic [31:0] wdata,
        input logic [31:0] exp_rd,
        input logic        exp_bad,
        input logic        chk_rd
    );
        exp_t e;
        en[d]  = 1'b1;
        wen[d] = w;
        sz[d]  = s;
        ad[d]  = a;
        nwd[d] = wdata;
        e.rd     = exp_rd;
        e.bad    = exp_bad;
        e.chk_rd = chk_rd;
        sb.push_back(e);
    endtask

    task automatic idle(input int d);
        en[d] = 1'b0;
    endtask

    task automatic check_phase(
        input int    d,
        input int    w,
        input string tag
    );
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (wt[d] === 1'b1 && n < 20) begin
            n++;
            clock(d);
            @(negedge clk);
        end
        chk({tag, "_waitlen"}, 32'(n), 32'(w));
        chk({tag, "_pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_bad"}, {31'b0, be[d]}, {31'b0, e.bad});
            if (e.chk_rd) chk({tag, "_rdata"}, rd[d], e.rd);
        end
    endtask

    task automatic single(
        input int          d,
        input int          w,
        input logic        wr,
        input logic [2:0]  s,
        input logic [31:0] a,
        input logic [31:0] wdata,
        input logic [31:0] exp_rd,
        input logic        exp_bad,
        input logic        chk_rd,
        input string       tag
    );
        addr_phase(d, wr, s, a, wdata, exp_rd, exp_bad, chk_rd);
        clock(d);
        idle(d);
        check_phase(d, w, tag);
        clock(d);
    endtask

    task automatic st_ld(
        input logic [2:0]  s,
        input logic [31:0] sa,
        input logic [31:0] swd,
        input logic [31:0] la,
        input logic [31:0] lexp,
        input string       tag
    );
        addr_phase(0, 1'b1, s, sa, swd, 32'h0, 1'b0, 1'b0);
        clock(0);
        addr_phase(0, 1'b0, WORD, la, 32'h0, lexp, 1'b0, 1'b1);
        check_phase(0, 0, {tag, "_st"});
        clock(0);
        idle(0);
        check_phase(0, 0, {tag, "_ld"});
        clock(0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            en[i]  = 1'b0;
            wen[i] = 1'b0;
            sz[i]  = WORD;
            ad[i]  = 32'h0;
            wd[i]  = 32'h0;
            nwd[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_wait", {31'b0, wt[0]}, 32'd0);
            chk("idle_bad", {31'b0, be[0]}, 32'd0);
            chk("idle_rdata", rd[0], 32'h0);
        end
        chk("rst_w3_wait", {31'b0, wt[1]}, 32'd0);
        chk("rst_w3_rdata", rd[1], 32'h0);
        chk("rst_w2_bad", {31'b0, be[2]}, 32'd0);
        @(posedge clk);
        #1;

        st_ld(WORD, 32'h10, 32'hDEAD_BEEF,
              32'h10, 32'hDEAD_BEEF, "fwd_word");
        single(0, 0, 1'b0, WORD, 32'h10, 32'h0,
               32'hDEAD_BEEF, 1'b0, 1'b1, "lw_array");
        @(negedge clk);
        chk("rdata_hold", rd[0], 32'hDEAD_BEEF);
        chk("hold_wait", {31'b0, wt[0]}, 32'd0);
        @(posedge clk);
        #1;

        single(0, 0, 1'b1, WORD, 32'h10, 32'h1122_3344,
               32'h0, 1'b0, 1'b0, "sw_base");
        single(0, 0, 1'b1, BYTE, 32'h13, 32'h5555_5555,
               32'h0, 1'b0, 1'b0, "sb_13");
        single(0, 0, 1'b0, WORD, 32'h10, 32'h0,
               32'h5522_3344, 1'b0, 1'b1, "lw_merge");
        st_ld(BYTE, 32'h11, 32'hAAAA_AAAA,
              32'h10, 32'h5522_AA44, "fwd_byte");

        single(0, 0, 1'b1, WORD, 32'h0, 32'hCAFE_F00D,
               32'h0, 1'b0, 1'b0, "sw_zero");
        single(0, 0, 1'b0, HALF, 32'h1, 32'h0,
               32'h0, 1'b1, 1'b1, "bad_lh");
        single(0, 0, 1'b1, WORD, 32'h4000, 32'h1234_5678,
               32'h0, 1'b1, 1'b1, "bad_range");
        single(0, 0, 1'b0, WORD, 32'h0, 32'h0,
               32'hCAFE_F00D, 1'b0, 1'b1, "rb_zero");
        single(0, 0, 1'b1, ILLSZ, 32'h10, 32'hFFFF_FFFF,
               32'h0, 1'b1, 1'b1, "bad_size");
        single(0, 0, 1'b0, WORD, 32'h10, 32'h0,
               32'h5522_AA44, 1'b0, 1'b1, "rb_10");
        single(0, 0, 1'b0, WORD, 32'h2, 32'h0,
               32'h0, 1'b1, 1'b1, "bad_lw_mis");

        single(1, 3, 1'b1, WORD, 32'h20, 32'hA5A5_A5A5,
               32'h0, 1'b0, 1'b0, "w3_sw");
        addr_phase(1, 1'b0, WORD, 32'h20, 32'h0,
                   32'hA5A5_A5A5, 1'b0, 1'b1);
        clock(1);
        addr_phase(1, 1'b0, WORD, 32'h22, 32'h0,
                   32'h0, 1'b1, 1'b1);
        check_phase(1, 3, "w3_lw");
        clock(1);
        idle(1);
        check_phase(1, 3, "w3_next");
        clock(1);

        single(2, 2, 1'b1, WORD, 32'h30, 32'h0BAD_F00D,
               32'h0, 1'b0, 1'b0, "w2_sw");
        en[2]  = 1'b1;
        wen[2] = 1'b1;
        sz[2]  = WORD;
        ad[2]  = 32'h30;
        nwd[2] = 32'hFFFF_FFFF;
        clock(2);
        idle(2);
        @(negedge clk);
        chk("w2_in_wait", {31'b0, wt[2]}, 32'd1);
        rst[2] = 1'b1;
        @(negedge clk);
        chk("w2_rst_wait", {31'b0, wt[2]}, 32'd0);
        chk("w2_rst_bad", {31'b0, be[2]}, 32'd0);
        chk("w2_rst_rdata", rd[2], 32'h0);
        rst[2] = 1'b0;
        @(negedge clk);
        chk("w2_post_wait", {31'b0, wt[2]}, 32'd0);
        @(posedge clk);
        #1;
        single(2, 2, 1'b0, WORD, 32'h30, 32'h0,
               32'h0BAD_F00D, 1'b0, 1'b1, "w2_rb");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
        $finish;
    end

endmodule
